// File: rtl/requant_pipeline.sv
// requant_pipeline: multi-lane requantisation stage between the MAC array and
// the activation buffer. Three registered stages:
//   S1 zero-point correction (acc - Z*ai) plus capture of multiplier/bias/mode,
//   S2 full-width signed x unsigned multiply,
//   S3 round-half-up shift, bias add, clamp to OUT_W (registered into out).
// A single global stall (out_valid & ~out_ready) freezes every stage.
module requant_pipeline #(
  parameter int               N_CH      = 4,
  parameter int               ACC_W     = 32,
  parameter int               OUT_W     = 8,
  parameter int               Z_WEIGHTS = 5,
  parameter int               MUL_W     = 32,
  parameter int               SHIFT     = 32,
  parameter logic [MUL_W-1:0] M_DEFAULT = 32'd2094967296
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*ACC_W-1:0]     acc,
  input  logic [N_CH*ACC_W-1:0]     ai,
  input  logic [N_CH*ACC_W-1:0]     bias,
  input  logic                      relu_mode,
  input  logic                      cfg_we,
  input  logic [$clog2(N_CH)-1:0]   cfg_ch,
  input  logic [MUL_W-1:0]          cfg_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*OUT_W-1:0]     out
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int DIFF_W = ACC_W + 8;
  localparam int PROD_W = DIFF_W + MUL_W + 1;
  // Two guard bits: one for the rounding add, one for the bias add.
  localparam int SUM_W  = PROD_W + 2;

  localparam logic signed [DIFF_W-1:0] ZW_EXT = DIFF_W'(Z_WEIGHTS);
  localparam logic signed [SUM_W-1:0]  RND    = SUM_W'(1) <<< (SHIFT - 1);
  localparam logic signed [SUM_W-1:0]  ZERO   = SUM_W'(0);
  localparam logic signed [SUM_W-1:0]  U_MAX  = (SUM_W'(1) <<< OUT_W) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0]  S_MAX  = (SUM_W'(1) <<< (OUT_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0]  S_MIN  = -S_MAX - SUM_W'(1);

  // Multiplier register file
  logic [MUL_W-1:0]         mul_r   [N_CH];

  // Stage 1 registers
  logic                     v1_r;
  logic signed [DIFF_W-1:0] diff_r  [N_CH];
  logic [MUL_W-1:0]         m1_r    [N_CH];
  logic signed [ACC_W-1:0]  bias1_r [N_CH];
  logic                     relu1_r;

  // Stage 2 registers
  logic                     v2_r;
  logic signed [PROD_W-1:0] prod_r  [N_CH];
  logic signed [ACC_W-1:0]  bias2_r [N_CH];
  logic                     relu2_r;

  // Combinational per-stage results
  logic                     stall_s;
  logic                     accept_s;
  logic signed [DIFF_W-1:0] diff_s  [N_CH];
  logic signed [PROD_W-1:0] prod_s  [N_CH];
  logic signed [SUM_W-1:0]  sum_s   [N_CH];
  logic [OUT_W-1:0]         sat_s   [N_CH];

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;
  assign accept_s = in_valid & in_ready;

  // Zero-point correction at full width so Z*ai can never wrap.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      diff_s[i] = DIFF_W'($signed(acc[i*ACC_W +: ACC_W]))
                - ZW_EXT * DIFF_W'($signed(ai[i*ACC_W +: ACC_W]));
    end
  end

  // Signed diff times zero-extended multiplier, no truncation.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      prod_s[i] = PROD_W'(diff_r[i]) * $signed(PROD_W'(m1_r[i]));
    end
  end

  // Round-half-up shift (same for both signs), bias add, then clamp.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sum_s[i] = ((SUM_W'(prod_r[i]) + RND) >>> SHIFT) + SUM_W'(bias2_r[i]);
      if (relu2_r) begin
        if (sum_s[i] < ZERO) begin
          sat_s[i] = {OUT_W{1'b0}};
        end else if (sum_s[i] > U_MAX) begin
          sat_s[i] = {OUT_W{1'b1}};
        end else begin
          sat_s[i] = sum_s[i][OUT_W-1:0];
        end
      end else begin
        if (sum_s[i] < S_MIN) begin
          sat_s[i] = {1'b1, {(OUT_W-1){1'b0}}};
        end else if (sum_s[i] > S_MAX) begin
          sat_s[i] = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          sat_s[i] = sum_s[i][OUT_W-1:0];
        end
      end
    end
  end

  // Multiplier writes land at the edge, so a beat accepted on the same edge sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mul_r[i] <= M_DEFAULT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          mul_r[i] <= cfg_data;
        end
      end
    end
  end

  // Pipeline stages: everything holds while stalled, bubbles advance otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      out       <= {(N_CH*OUT_W){1'b0}};
      relu1_r   <= 1'b0;
      relu2_r   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        diff_r[i]  <= {DIFF_W{1'b0}};
        m1_r[i]    <= {MUL_W{1'b0}};
        bias1_r[i] <= {ACC_W{1'b0}};
        prod_r[i]  <= {PROD_W{1'b0}};
        bias2_r[i] <= {ACC_W{1'b0}};
      end
    end else if (!stall_s) begin
      v1_r      <= accept_s;
      v2_r      <= v1_r;
      out_valid <= v2_r;
      if (accept_s) begin
        relu1_r <= relu_mode;
        for (int i = 0; i < N_CH; i++) begin
          diff_r[i]  <= diff_s[i];
          m1_r[i]    <= mul_r[i];
          bias1_r[i] <= $signed(bias[i*ACC_W +: ACC_W]);
        end
      end
      if (v1_r) begin
        relu2_r <= relu1_r;
        for (int i = 0; i < N_CH; i++) begin
          prod_r[i]  <= prod_s[i];
          bias2_r[i] <= bias1_r[i];
        end
      end
      if (v2_r) begin
        for (int i = 0; i < N_CH; i++) begin
          out[i*OUT_W +: OUT_W] <= sat_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_requant_pipeline.sv
// tb_requant_pipeline: scoreboard bench for requant_pipeline (default params).
// Expected beats are computed by a wide-integer model when a beat is accepted,
// queued, and compared by a monitor when the DUT hands a beat over.
module tb_requant_pipeline;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] acc;
  logic [127:0] ai;
  logic [127:0] bias;
  logic         relu_mode;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [31:0]  cfg_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out;

  localparam logic [31:0] M_DEF = 32'd2094967296;
  localparam logic [31:0] M_HALF = 32'h8000_0000;
  localparam logic [31:0] M_QUARTER = 32'h4000_0000;

  logic [31:0] m_model [4];
  logic [31:0] sb [$];
  int          vectors;
  int          miscompares;
  int          hs_cnt;
  bit          last_acc;
  bit          last_ov;
  bit          last_rdy;
  logic [31:0] last_out;
  bit          hold_chk;
  logic [31:0] held_out;

  requant_pipeline dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc(acc), .ai(ai), .bias(bias), .relu_mode(relu_mode),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_lane(input logic signed [31:0] a, input logic signed [31:0] x,
                                            input logic signed [31:0] b, input logic [31:0] m, input bit rl);
    logic signed [127:0] d, mm, p, r, s;
    d  = 128'(a) - 128'sd5 * 128'(x);
    mm = $signed({96'd0, m});
    p  = d * mm;
    r  = (p + (128'sd1 <<< 31)) >>> 32;
    s  = r + 128'(b);
    if (rl) begin
      if (s < 128'sd0) return 8'd0;
      if (s > 128'sd255) return 8'd255;
      return s[7:0];
    end
    if (s < -128'sd128) return 8'h80;
    if (s > 128'sd127) return 8'h7F;
    return s[7:0];
  endfunction

  function automatic logic [31:0] expected_beat(input logic [127:0] a, input logic [127:0] x,
                                                input logic [127:0] b, input bit rl);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = model_lane(a[i*32 +: 32], x[i*32 +: 32], b[i*32 +: 32], m_model[i], rl);
    end
    return r;
  endfunction

  function automatic logic [127:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x3, x2, x1, x0};
  endfunction

  // One clock of stimulus; expected beat is queued when the DUT accepts.
  task automatic step(input bit iv, input logic [127:0] a, input logic [127:0] x, input logic [127:0] b,
                      input bit rl, input bit ordy, input bit we, input logic [1:0] ch, input logic [31:0] d);
    @(negedge clk);
    in_valid = iv; acc = a; ai = x; bias = b; relu_mode = rl;
    out_ready = ordy; cfg_we = we; cfg_ch = ch; cfg_data = d;
    #1;
    last_ov  = out_valid;
    last_out = out;
    last_rdy = in_ready;
    last_acc = iv && in_ready;
    if (last_acc && !rst) sb.push_back(expected_beat(a, x, b, rl));
    @(posedge clk);
    if (we && !rst) m_model[ch] = d;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, 128'd0, 128'd0, 1'b0, ordy, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      idle(1, 1'b1);
      k++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
    end
  endtask

  // Scoreboard monitor: compares every handshake and checks hold under backpressure.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    #1;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: out=%h appeared with no beat expected", out);
      end else begin
        exp_v = sb.pop_front();
        if (out !== exp_v) begin
          miscompares++;
          $display("FAIL sb_data: out=%h required %h", out, exp_v);
        end
      end
    end
    if (hold_chk && !rst) begin
      vectors++;
      if (out_valid !== 1'b1 || out !== held_out) begin
        miscompares++;
        $display("FAIL hold: out_valid=%b out=%h required 1 %h", out_valid, out, held_out);
      end
    end
    hold_chk = !rst && out_valid === 1'b1 && out_ready === 1'b0;
    held_out = out;
  end

  task automatic reset_model();
    sb.delete();
    for (int i = 0; i < 4; i++) m_model[i] = M_DEF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    idle(2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b0);
    vectors++;
    if (last_ov !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", last_ov); end
    vectors++;
    if (last_out !== 32'd0) begin miscompares++; $display("FAIL reset_out: got %h required 0", last_out); end
    vectors++;
    if (last_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", last_rdy); end
  endtask

  task automatic test_cfg_init();
    for (int i = 0; i < 4; i++) step(1'b0, 128'd0, 128'd0, 128'd0, 1'b0, 1'b1, 1'b1, 2'(i), M_HALF);
  endtask

  task automatic test_basic();
    step(1'b1, pack4(300, 300, 300, 300), pack4(20, 20, 20, 20), pack4(3, 3, 3, 3), 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    idle(1, 1'b1);
    vectors++;
    if (last_ov !== 1'b0) begin miscompares++; $display("FAIL basic_lat1: out_valid=%b required 0", last_ov); end
    idle(1, 1'b1);
    vectors++;
    if (last_ov !== 1'b0) begin miscompares++; $display("FAIL basic_lat2: out_valid=%b required 0", last_ov); end
    idle(1, 1'b1);
    vectors++;
    if (last_ov !== 1'b1 || last_out !== {4{8'd103}}) begin
      miscompares++;
      $display("FAIL basic_lat3: out_valid=%b out=%h required 1 %h", last_ov, last_out, {4{8'd103}});
    end
    drain();
  endtask

  task automatic test_rounding();
    step(1'b1, pack4(3, -3, -1, 5), pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
    idle(3, 1'b1);
    vectors++;
    if (last_out !== {8'd3, 8'd0, 8'hFF, 8'd2}) begin
      miscompares++;
      $display("FAIL rounding: out=%h required %h", last_out, {8'd3, 8'd0, 8'hFF, 8'd2});
    end
    drain();
  endtask

  task automatic test_saturation();
    step(1'b1, pack4(0, 2000, 300, -2000), pack4(10, 0, 20, 0), pack4(0, 0, 3, 0), 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b1, pack4(2000, -2000, 7, 0), pack4(0, 0, 0, 1), pack4(0, 0, -10, 0), 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
    idle(2, 1'b1);
    vectors++;
    if (last_out !== {8'd0, 8'd103, 8'd255, 8'd0}) begin
      miscompares++;
      $display("FAIL sat_relu: out=%h required %h", last_out, {8'd0, 8'd103, 8'd255, 8'd0});
    end
    idle(1, 1'b1);
    vectors++;
    if (last_out !== {8'hFE, 8'hFA, 8'h80, 8'h7F}) begin
      miscompares++;
      $display("FAIL sat_signed: out=%h required %h", last_out, {8'hFE, 8'hFA, 8'h80, 8'h7F});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pack4(i * 40, -i * 30, i * 7, 1000 - i * 300), pack4(i, 2, -i, 0), pack4(i, -i, 0, 5),
           i[0], 1'b1, 1'b0, 2'd0, 32'd0);
      vectors++;
      if (last_acc !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: beat %0d accepted=%b required 1", i, last_acc); end
    end
    drain();
    vectors++;
    if (hs_cnt - start !== 8) begin miscompares++; $display("FAIL b2b_count: got %0d outputs required 8", hs_cnt - start); end
  endtask

  task automatic test_backpressure();
    int sent, k, start;
    logic [127:0] a, x, b;
    bit rl, ordy;
    sent = 0; k = 0; start = hs_cnt;
    for (int l = 0; l < 4; l++) begin
      a[l*32 +: 32] = int'($urandom_range(0, 4000)) - 2000;
      x[l*32 +: 32] = int'($urandom_range(0, 400)) - 200;
      b[l*32 +: 32] = int'($urandom_range(0, 200)) - 100;
    end
    rl = 1'($urandom_range(0, 1));
    while ((sent < 10 || sb.size() != 0) && k < 100) begin
      ordy = (k >= 4 && k <= 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(sent < 10, a, x, b, rl, ordy, 1'b0, 2'd0, 32'd0);
      vectors++;
      if (last_rdy !== !(last_ov && !ordy)) begin
        miscompares++;
        $display("FAIL bp_in_ready: got %b required %b", last_rdy, !(last_ov && !ordy));
      end
      if (last_acc) begin
        sent++;
        for (int l = 0; l < 4; l++) begin
          a[l*32 +: 32] = int'($urandom_range(0, 4000)) - 2000;
          x[l*32 +: 32] = int'($urandom_range(0, 400)) - 200;
          b[l*32 +: 32] = int'($urandom_range(0, 200)) - 100;
        end
        rl = 1'($urandom_range(0, 1));
      end
      k++;
    end
    vectors++;
    if (hs_cnt - start !== 10 || sent !== 10) begin
      miscompares++;
      $display("FAIL bp_count: sent %0d got %0d outputs required 10", sent, hs_cnt - start);
    end
  endtask

  task automatic test_cfg_timing();
    step(1'b1, pack4(400, 400, 400, 400), 128'd0, 128'd0, 1'b1, 1'b1, 1'b1, 2'd2, M_QUARTER);
    step(1'b1, pack4(400, 400, 400, 400), 128'd0, 128'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    idle(2, 1'b1);
    vectors++;
    if (last_out !== {4{8'd200}}) begin
      miscompares++;
      $display("FAIL cfg_beat_a: out=%h required %h", last_out, {4{8'd200}});
    end
    idle(1, 1'b1);
    vectors++;
    if (last_out !== {8'd200, 8'd100, 8'd200, 8'd200}) begin
      miscompares++;
      $display("FAIL cfg_beat_b: out=%h required %h", last_out, {8'd200, 8'd100, 8'd200, 8'd200});
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pack4(500, 600, 700, 800), pack4(i, i, i, i), 128'd0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    end
    rst = 1'b1;
    idle(1, 1'b0);
    reset_model();
    rst = 1'b0;
    idle(1, 1'b0);
    vectors++;
    if (last_ov !== 1'b0 || last_out !== 32'd0 || last_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_state: out_valid=%b out=%h in_ready=%b required 0 0 1", last_ov, last_out, last_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      vectors++;
      if (last_ov !== 1'b0) begin miscompares++; $display("FAIL midrst_stale: out_valid=%b required 0", last_ov); end
    end
    step(1'b1, pack4(100, 100, 100, 100), 128'd0, 128'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    idle(3, 1'b1);
    vectors++;
    if (last_out !== {4{8'd49}}) begin
      miscompares++;
      $display("FAIL midrst_mdefault: out=%h required %h", last_out, {4{8'd49}});
    end
    drain();
  endtask

  initial begin
    vectors = 0; miscompares = 0; hs_cnt = 0; hold_chk = 1'b0; held_out = 32'd0;
    rst = 1'b1; in_valid = 1'b0; acc = 128'd0; ai = 128'd0; bias = 128'd0; relu_mode = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_data = 32'd0; out_ready = 1'b0;
    test_reset();
    test_cfg_init();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_cfg_timing();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
